reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised power-on/lock-loss reset generator for the MKR Vidor 4000 FPGA top level; successor to the single free-running 6-bit reset counter. Qualifies the system PLL lock with a debounce filter, then releases CHANNELS active-high reset outputs one at a time, STAGE_DELAY clocks apart. Any lock loss or software reset request re-asserts all outputs at once, and lock-loss events are counted. One instance per clock domain; this instance runs on the memory clock.

## Interface
Parameters:
- CHANNELS, 4: number of staged reset outputs; ≥1
- STAGE_DELAY, 32: clocks between successive channel releases; ≥1
- LOCK_FILTER, 8: consecutive synchronised-high lock cycles required; ≥1

Ports:
- iCLK  in  1  sole clock; all logic on rising edge
- iRESET  in  1  asynchronous, active-high; sets all state to reset values
- iLOCKED  in  1  PLL locked, asynchronous to iCLK; synchronised internally
- iSW_RESET  in  1  synchronous software reset request, level-sensitive
- oRESET  out  CHANNELS  per-channel active-high reset; bit 0 released first
- oREADY  out  1  high when all channels are released
- oSTATE  out  2  current FSM state encoding
- oFAULT_CNT  out  8  saturating count of lock-loss events while not in HOLD

## Operation
- iLOCKED passes through a 2-flop synchroniser. lk_s is the synchroniser output.
- FSM states: HOLD=0, RELEASE=1, RUN=2. Encoding 3 is unused and recovers to HOLD on the next edge.
- HOLD:
  - All oRESET bits are 1.
  - The filter counter increments while lk_s=1 and clears when lk_s=0.
  - When lk_s=1, the filter counter equals LOCK_FILTER-1, and iSW_RESET=0: go to RELEASE, stage=0, delay counter=0.
- RELEASE:
  - The delay counter counts 0..STAGE_DELAY-1.
  - At terminal count, clear oRESET[stage] and reset the delay counter.
  - If stage==CHANNELS-1, go to RUN; otherwise increment stage.
- RUN:
  - oRESET is all 0 and oREADY=1.
- Abort (from RELEASE or RUN):
  - Trigger is lk_s=0 or iSW_RESET=1.
  - On the next edge: oRESET all 1, oREADY=0, state HOLD, all counters cleared.
  - Abort has priority over any release due on the same edge.
- Fault count:
  - oFAULT_CNT increments on an abort caused by lk_s=0; iSW_RESET alone does not count.
  - It saturates at 255 and is cleared only by iRESET.
- While iSW_RESET stays high, the block remains in HOLD.
- Counter widths: $clog2(LOCK_FILTER+1), $clog2(STAGE_DELAY+1), and max(1,$clog2(CHANNELS)). No wrap-around is reachable.

## Timing
- Reset values: oRESET all 1, oREADY 0, oSTATE 0, oFAULT_CNT 0, synchroniser flops 0.
- Lock to first release: if iLOCKED is first sampled high at edge E and stays high, oRESET[0] falls at edge E+2+LOCK_FILTER+STAGE_DELAY.
- Each following channel k falls at that edge + k·STAGE_DELAY.
- oREADY rises on the same edge that clears oRESET[CHANNELS-1].
- Defaults: ch0 at E+42, ch3 and oREADY at E+138.
- Lock-loss reaction: iLOCKED low sampled at edge F gives oRESET all 1 at edge F+3 (2 synchroniser + 1 FSM). iSW_RESET high at edge F gives assertion at F+1.
- Glitch filtering: a lk_s low pulse of one cycle in HOLD restarts the filter from 0.
- iRESET assertion mid-sequence: outputs go to reset values immediately, without waiting for a clock.
- iRESET deassertion: takes effect on the first iCLK edge; the top level is responsible for synchronising deassertion.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Package reset_seq_pkg holds the state enum (HOLD, RELEASE, RUN) and a 2-bit state width constant.
- One sub-module, sync_2ff: single-bit 2-flop synchroniser with iCLK/iRESET and reset value 0. Reused later for other asynchronous inputs.
- Everything else is a single FSM process plus output registers in reset_sequencer.

## Test plan
- Clean lock, defaults: iRESET pulse, then iLOCKED=1 from edge 10 → oRESET goes 4'b1110 at edge 52, 4'b1100 at 84, 4'b1000 at 116, 4'b0000 with oREADY=1 at 148.
- Lock glitch in HOLD: iLOCKED high 5 cycles, low 1, then high → oRESET[0] release is delayed until 2+8+32 cycles after the final rise; oFAULT_CNT stays 0.
- Lock loss in RUN: drop iLOCKED at edge F → oRESET=4'b1111, oREADY=0, oSTATE=0 at F+3; oFAULT_CNT=1; full re-sequence after relock.
- Software reset mid-RELEASE after ch1 released: iSW_RESET high 3 cycles → all outputs asserted next edge; oFAULT_CNT unchanged; the sequence restarts from ch0 LOCK_FILTER cycles after iSW_RESET falls.
- Saturation: 300 lock-loss/relock cycles → oFAULT_CNT reads 255. Async iRESET mid-RELEASE → outputs return to reset values without a clock edge.
- Parameter sweep: CHANNELS=1, STAGE_DELAY=1, LOCK_FILTER=1 → oRESET falls 4 edges after iLOCKED is sampled high, together with oREADY.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
//   Shared definitions for the staged reset sequencer: the FSM state
//   encoding and its width. Encoding 3 is deliberately left unused.
package reset_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seqState_t;

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// sync_2ff
//   Single-bit two-flop synchroniser for an input that is asynchronous to
//   iCLK. Both flops clear to 0 on iRESET.
// Ports:
//   iCLK    in  1  destination clock
//   iRESET  in  1  asynchronous active-high reset
//   iD      in  1  asynchronous input
//   oQ      out 1  synchronised output (two iCLK edges of latency)
module sync_2ff (
  input  logic iCLK,
  input  logic iRESET,
  input  logic iD,
  output logic oQ
);

  logic metaReg;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      metaReg <= 1'b0;
      oQ      <= 1'b0;
    end else begin
      metaReg <= iD;
      oQ      <= metaReg;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Power-on / lock-loss reset generator. The PLL lock is synchronised and
//   debounced; once it has been high for LOCK_FILTER consecutive cycles the
//   CHANNELS reset outputs are released one at a time, STAGE_DELAY clocks
//   apart, bit 0 first. Loss of lock or a software reset request re-asserts
//   every output on the next edge. Lock-loss aborts are counted (saturating).
// Ports:
//   iCLK        in  1         clock, rising edge
//   iRESET      in  1         asynchronous active-high reset
//   iLOCKED     in  1         PLL locked (asynchronous, synchronised here)
//   iSW_RESET   in  1         synchronous software reset request (level)
//   oRESET      out CHANNELS  per-channel active-high reset
//   oREADY      out 1         all channels released
//   oSTATE      out 2         FSM state (0 HOLD, 1 RELEASE, 2 RUN)
//   oFAULT_CNT  out 8         saturating lock-loss count
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int STAGE_DELAY = 32,
  parameter int LOCK_FILTER = 8
) (
  input  logic                iCLK,
  input  logic                iRESET,
  input  logic                iLOCKED,
  input  logic                iSW_RESET,
  output logic [CHANNELS-1:0] oRESET,
  output logic                oREADY,
  output logic [1:0]          oSTATE,
  output logic [7:0]          oFAULT_CNT
);

  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int DLY_W  = $clog2(STAGE_DELAY + 1);
  localparam int STG_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DELAY - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(CHANNELS - 1);

  localparam logic [STATE_W-1:0] sHold    = HOLD;
  localparam logic [STATE_W-1:0] sRelease = RELEASE;
  localparam logic [STATE_W-1:0] sRun     = RUN;

  logic               lkS;
  logic [STATE_W-1:0] stateReg;
  logic [FILT_W-1:0]  filtCnt;
  logic [DLY_W-1:0]   dlyCnt;
  logic [STG_W-1:0]   stage;
  logic               abortReq;

  sync_2ff lockSync (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .iD     (iLOCKED),
    .oQ     (lkS)
  );

  // Either source of abort; only the lock-loss one is counted as a fault.
  assign abortReq = !lkS || iSW_RESET;
  assign oSTATE   = stateReg;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      stateReg   <= sHold;
      filtCnt    <= '0;
      dlyCnt     <= '0;
      stage      <= '0;
      oRESET     <= '1;
      oREADY     <= 1'b0;
      oFAULT_CNT <= 8'd0;
    end else begin
      case (stateReg)
        sHold: begin
          oRESET <= '1;
          oREADY <= 1'b0;
          // A software request holds the filter at zero, so qualification
          // restarts only once the request is withdrawn.
          if (lkS && !iSW_RESET) begin
            if (filtCnt == FILT_LAST) begin
              stateReg <= sRelease;
              filtCnt  <= '0;
              dlyCnt   <= '0;
              stage    <= '0;
            end else begin
              filtCnt <= filtCnt + FILT_W'(1);
            end
          end else begin
            filtCnt <= '0;
          end
        end

        sRelease, sRun: begin
          if (abortReq) begin
            // Abort wins over a release falling due on the same edge.
            stateReg <= sHold;
            filtCnt  <= '0;
            dlyCnt   <= '0;
            stage    <= '0;
            oRESET   <= '1;
            oREADY   <= 1'b0;
            if (!lkS && oFAULT_CNT != 8'hFF)
              oFAULT_CNT <= oFAULT_CNT + 8'd1;
          end else if (stateReg == sRelease) begin
            if (dlyCnt == DLY_LAST) begin
              dlyCnt        <= '0;
              oRESET[stage] <= 1'b0;
              if (stage == STG_LAST) begin
                stateReg <= sRun;
                oREADY   <= 1'b1;
              end else begin
                stage <= stage + STG_W'(1);
              end
            end else begin
              dlyCnt <= dlyCnt + DLY_W'(1);
            end
          end
        end

        default: begin
          // Unused encoding: fall back to a fully asserted HOLD.
          stateReg <= sHold;
          filtCnt  <= '0;
          dlyCnt   <= '0;
          stage    <= '0;
          oRESET   <= '1;
          oREADY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int CH = 4;
  localparam int SD = 32;
  localparam int LF = 8;

  logic wMEM_CLK = 1'b0;
  always #5 wMEM_CLK = ~wMEM_CLK;

  logic          rst;
  logic          locked;
  logic          swReset;
  logic [CH-1:0] rstOut;
  logic          ready;
  logic [1:0]    state;
  logic [7:0]    faultCnt;

  logic          locked2;
  logic [0:0]    rstOut2;
  logic          ready2;
  logic [1:0]    state2;
  logic [7:0]    faultCnt2;

  reset_sequencer #(.CHANNELS(CH), .STAGE_DELAY(SD), .LOCK_FILTER(LF)) dut (
    .iCLK       (wMEM_CLK),
    .iRESET     (rst),
    .iLOCKED    (locked),
    .iSW_RESET  (swReset),
    .oRESET     (rstOut),
    .oREADY     (ready),
    .oSTATE     (state),
    .oFAULT_CNT (faultCnt)
  );

  reset_sequencer #(.CHANNELS(1), .STAGE_DELAY(1), .LOCK_FILTER(1)) dutMin (
    .iCLK       (wMEM_CLK),
    .iRESET     (rst),
    .iLOCKED    (locked2),
    .iSW_RESET  (1'b0),
    .oRESET     (rstOut2),
    .oREADY     (ready2),
    .oSTATE     (state2),
    .oFAULT_CNT (faultCnt2)
  );

  int nCompared   = 0;
  int nMismatched = 0;
  int edgeN       = 0;

  // Reference model: lock history as a two-deep sample list, a run length
  // of qualifying lock cycles, and the edge at which releasing began.
  // Released channel count is derived arithmetically from elapsed edges.
  bit mS1, mS2;
  bit mHold;
  int mRun;
  int mRelStart;
  int mFault;

  typedef struct {
    int           edgeAt;
    bit           lk;
    bit           sw;
    logic [3:0]   eR;
    bit           eRdy;
    logic [1:0]   eSt;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edgeN);
    end
  endtask

  task automatic modelReset();
    mS1 = 0; mS2 = 0; mHold = 1; mRun = 0; mRelStart = 0; mFault = 0;
  endtask

  task automatic step();
    bit lkS;
    int k;
    logic [CH-1:0] eR;
    bit eRdy;
    logic [1:0] eSt;
    @(posedge wMEM_CLK);
    edgeN++;
    if (rst) begin
      modelReset();
    end else begin
      lkS = mS2;
      mS2 = mS1;
      mS1 = locked;
      if (!mHold) begin
        if (!lkS || swReset) begin
          mHold = 1;
          mRun  = 0;
          if (!lkS && mFault < 255) mFault++;
        end
      end else if (lkS && !swReset) begin
        if (mRun == LF - 1) begin
          mHold = 0;
          mRelStart = edgeN;
          mRun = 0;
        end else begin
          mRun++;
        end
      end else begin
        mRun = 0;
      end
    end
    #1;
    if (mHold) begin
      eR = '1; eRdy = 0; eSt = 2'd0;
    end else begin
      k = (edgeN - mRelStart) / SD;
      if (k > CH) k = CH;
      eR = '1;
      for (int i = 0; i < CH; i++) if (i < k) eR[i] = 1'b0;
      eRdy = (k == CH);
      eSt  = (k == CH) ? 2'd2 : 2'd1;
    end
    check("mdl_oRESET", rstOut, eR);
    check("mdl_oREADY", ready, eRdy);
    check("mdl_oSTATE", state, eSt);
    check("mdl_oFAULT_CNT", faultCnt, mFault);
  endtask

  task automatic applyReset();
    rst = 1; locked = 0; swReset = 0; locked2 = 0;
    modelReset();
    repeat (2) @(posedge wMEM_CLK);
    #1;
    rst = 0;
    edgeN = 0;
  endtask

  task automatic waitState(input logic [1:0] s, input int maxCyc, input string name);
    int n;
    n = 0;
    while (state !== s && n < maxCyc) begin
      step();
      n++;
    end
    check(name, state, s);
  endtask

  task automatic waitRst(input logic [CH-1:0] p, input int maxCyc, input string name);
    int n;
    n = 0;
    while (rstOut !== p && n < maxCyc) begin
      step();
      n++;
    end
    check(name, rstOut, p);
  endtask

  initial begin
    int fEdge, gEdge, rEdge, len;

    vecs[0]  = '{5,   0, 0, 4'b1111, 0, 2'd0};
    vecs[1]  = '{10,  1, 0, 4'b1111, 0, 2'd0};
    vecs[2]  = '{19,  1, 0, 4'b1111, 0, 2'd0};
    vecs[3]  = '{20,  1, 0, 4'b1111, 0, 2'd1};
    vecs[4]  = '{51,  1, 0, 4'b1111, 0, 2'd1};
    vecs[5]  = '{52,  1, 0, 4'b1110, 0, 2'd1};
    vecs[6]  = '{83,  1, 0, 4'b1110, 0, 2'd1};
    vecs[7]  = '{84,  1, 0, 4'b1100, 0, 2'd1};
    vecs[8]  = '{115, 1, 0, 4'b1100, 0, 2'd1};
    vecs[9]  = '{116, 1, 0, 4'b1000, 0, 2'd1};
    vecs[10] = '{147, 1, 0, 4'b1000, 0, 2'd1};
    vecs[11] = '{148, 1, 0, 4'b0000, 1, 2'd2};
    vecs[12] = '{150, 1, 0, 4'b0000, 1, 2'd2};

    // Reset values
    rst = 1; locked = 0; swReset = 0; locked2 = 0;
    modelReset();
    repeat (3) @(posedge wMEM_CLK);
    #1;
    check("rst_oRESET", rstOut, 4'b1111);
    check("rst_oREADY", ready, 1'b0);
    check("rst_oSTATE", state, 2'd0);
    check("rst_oFAULT_CNT", faultCnt, 8'd0);
    check("rst_min_oRESET", rstOut2, 1'b1);
    rst = 0;
    edgeN = 0;
    $display("reset values checked");

    // Minimal parameters: lock driven after edge 2, release at edge 6
    repeat (2) step();
    locked2 = 1;
    repeat (2) step();
    check("min_e4_state", state2, 2'd0);
    step();
    check("min_e5_oRESET", rstOut2, 1'b1);
    check("min_e5_state", state2, 2'd1);
    check("min_e5_ready", ready2, 1'b0);
    step();
    check("min_e6_oRESET", rstOut2, 1'b0);
    check("min_e6_ready", ready2, 1'b1);
    check("min_e6_state", state2, 2'd2);
    $display("minimal-parameter release checked");

    // Clean lock, table driven
    applyReset();
    for (int v = 0; v < 13; v++) begin
      while (edgeN < vecs[v].edgeAt) step();
      check("vec_oRESET", rstOut, vecs[v].eR);
      check("vec_oREADY", ready, vecs[v].eRdy);
      check("vec_oSTATE", state, vecs[v].eSt);
      $display("vec %0d edge %0d oRESET=%b oREADY=%b oSTATE=%0d", v, edgeN, rstOut, ready, state);
      locked  = vecs[v].lk;
      swReset = vecs[v].sw;
    end

    // Lock loss in RUN
    fEdge = edgeN;
    locked = 0;
    repeat (2) step();
    check("loss_f2_state", state, 2'd2);
    check("loss_f2_oRESET", rstOut, 4'b0000);
    step();
    check("loss_f3_oRESET", rstOut, 4'b1111);
    check("loss_f3_ready", ready, 1'b0);
    check("loss_f3_state", state, 2'd0);
    check("loss_f3_fault", faultCnt, 8'd1);
    locked = 1;
    waitState(2'd2, 200, "loss_relock_run");
    $display("lock loss at edge %0d, re-sequenced by edge %0d", fEdge, edgeN);

    // Software reset mid-RELEASE, after ch1 released
    swReset = 1;
    step();
    swReset = 0;
    waitRst(4'b1100, 200, "sw_reach_ch1");
    swReset = 1;
    step();
    check("sw_assert_oRESET", rstOut, 4'b1111);
    check("sw_assert_state", state, 2'd0);
    check("sw_assert_fault", faultCnt, 8'd1);
    repeat (2) step();
    swReset = 0;
    gEdge = edgeN;
    repeat (LF - 1) step();
    check("sw_filter_hold", state, 2'd0);
    step();
    check("sw_filter_rel", state, 2'd1);
    repeat (SD - 1) step();
    check("sw_ch0_held", rstOut[0], 1'b1);
    step();
    check("sw_ch0_released", rstOut[0], 1'b0);
    $display("software reset dropped at edge %0d, ch0 released at edge %0d", gEdge, edgeN);

    // Lock glitch in HOLD
    applyReset();
    locked = 1;
    repeat (5) step();
    locked = 0;
    step();
    locked = 1;
    rEdge = edgeN;
    repeat (41) step();
    check("glitch_ch0_held", rstOut[0], 1'b1);
    step();
    check("glitch_ch0_released", rstOut[0], 1'b0);
    check("glitch_fault", faultCnt, 8'd0);
    $display("glitch: final rise at edge %0d, ch0 released at edge %0d", rEdge, edgeN);

    // Fault counter saturation
    for (int i = 0; i < 300; i++) begin
      locked = 0;
      repeat (4) step();
      locked = 1;
      waitState(2'd1, 60, "sat_relock");
    end
    check("sat_fault", faultCnt, 8'd255);
    $display("saturation: oFAULT_CNT=%0d after 300 lock losses", faultCnt);

    // Asynchronous reset mid-RELEASE, no clock edge in between
    repeat (5) step();
    check("async_pre_state", state, 2'd1);
    @(negedge wMEM_CLK);
    rst = 1;
    #1;
    check("async_oRESET", rstOut, 4'b1111);
    check("async_oREADY", ready, 1'b0);
    check("async_oSTATE", state, 2'd0);
    check("async_fault", faultCnt, 8'd0);
    modelReset();
    @(posedge wMEM_CLK);
    #1;
    rst = 0;
    locked = 0;
    edgeN = 0;
    $display("async reset mid-RELEASE checked");

    // Randomised segments against the reference model
    for (int seg = 0; seg < 60; seg++) begin
      locked  = ($urandom_range(0, 9) < 8);
      swReset = ($urandom_range(0, 19) == 0);
      len     = $urandom_range(1, 120);
      repeat (len) step();
      $display("rand seg %0d lk=%0b sw=%0b len=%0d state=%0d fault=%0d",
               seg, locked, swReset, len, state, faultCnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
